// File: rtl/e1_rx_bd_sched.sv
// E1 RX buffer-descriptor scheduler: ring-fed BD-In submits, BD-Out completion drain, release tracking.
// Optional macro E1_RX_BD_SCHED_SEQCHK_EN builds the completion sequence comparator.
module e1_rx_bd_sched #(
  parameter int MFW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctrl_run,
  input  logic           ctrl_flush,
  input  logic           rel_stb,
  input  logic           cnt_clr,
  output logic [MFW-1:0] bri_data,
  output logic           bri_wren,
  input  logic           bri_full,
  input  logic [MFW+1:0] bro_data,
  output logic           bro_rden,
  input  logic           bro_empty,
  output logic           cmp_valid,
  output logic [MFW-1:0] cmp_mf,
  output logic [1:0]     cmp_crc_e,
  input  logic           cmp_ack,
  output logic [1:0]     st_state,
  output logic [MFW:0]   st_inflight,
  output logic           st_seq_err,
  output logic [15:0]    crc_err_cnt,
  output logic           irq
);

  // state | meaning
  // IDLE  | no submits or pops, pointers held
  // RUN   | submit from ring and pop completions
  // DRAIN | pop only until done_ptr catches sub_ptr (or flush)
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  localparam logic [MFW:0] RING = {1'b1, {MFW{1'b0}}};
  localparam logic [MFW:0] ONE  = {{MFW{1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [MFW:0] sub_ptr, done_ptr, rel_ptr, done_nxt;
  logic         submit, pop, flush, seq_clr;
  logic         rel_ok, rel_bad, seq_mis;
  logic [1:0]   zeros;
  logic [16:0]  crc_sum;
  logic [15:0]  crc_cnt;
  logic         seq_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    submit    = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    seq_clr   = 1'b0;
    // One pop per two cycles; the register may be refilled in the cycle it is acked.
    if (state != S_IDLE)
      pop = !bro_empty && !bro_rden && (!cmp_valid || cmp_ack);
    case (state)
      S_IDLE: begin
        if (ctrl_run) begin
          state_nxt = S_RUN;
          seq_clr   = 1'b1;
        end
      end
      S_RUN: begin
        submit = !bri_full && !bri_wren && ((sub_ptr - rel_ptr) < RING);
        if (!ctrl_run) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (ctrl_flush) begin
          flush     = 1'b1;
          state_nxt = S_IDLE;
        end else if (ctrl_run) begin
          state_nxt = S_RUN;
        end else if (done_ptr == sub_ptr) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rel_ok   = rel_stb && (rel_ptr != done_ptr);
  assign rel_bad  = rel_stb && (rel_ptr == done_ptr);
  assign done_nxt = done_ptr + {{MFW{1'b0}}, pop};
  assign zeros    = {1'b0, ~bro_data[MFW+1]} + {1'b0, ~bro_data[MFW]};
  assign crc_sum  = {1'b0, crc_cnt} + {15'd0, zeros};

`ifdef E1_RX_BD_SCHED_SEQCHK_EN
  assign seq_mis = pop && (bro_data[MFW-1:0] != done_ptr[MFW-1:0]);
`else
  assign seq_mis = 1'b0;
`endif

  // Flush abandons everything in flight, including a completion popped on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_ptr  <= '0;
      done_ptr <= '0;
      rel_ptr  <= '0;
    end else begin
      done_ptr <= done_nxt;
      if (rel_ok) rel_ptr <= rel_ptr + ONE;
      if (flush)       sub_ptr <= done_nxt;
      else if (submit) sub_ptr <= sub_ptr + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bri_wren <= 1'b0;
      bri_data <= '0;
      bro_rden <= 1'b0;
    end else begin
      bri_wren <= submit;
      bro_rden <= pop;
      if (submit) bri_data <= sub_ptr[MFW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_mf    <= '0;
      cmp_crc_e <= 2'b00;
    end else if (pop) begin
      cmp_valid <= 1'b1;
      cmp_mf    <= bro_data[MFW-1:0];
      cmp_crc_e <= bro_data[MFW+1:MFW];
    end else if (cmp_ack) begin
      cmp_valid <= 1'b0;
    end
  end

  // A new error event wins over the clear on run start so it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     seq_err <= 1'b0;
    else if (seq_mis || rel_bad) seq_err <= 1'b1;
    else if (seq_clr)            seq_err <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc_cnt <= 16'h0000;
    else if (cnt_clr)
      crc_cnt <= 16'h0000;
    else if (pop && (zeros != 2'd0))
      crc_cnt <= crc_sum[16] ? 16'hFFFF : crc_sum[15:0];
  end

  assign st_state    = state;
  assign st_inflight = sub_ptr - done_ptr;
  assign st_seq_err  = seq_err;
  assign crc_err_cnt = crc_cnt;
  assign irq         = cmp_valid | seq_err;

endmodule

// File: tb/tb_e1_rx_bd_sched.sv
// Bench for e1_rx_bd_sched (MFW=3): FIFO/core emulation, behavioural model checked every cycle, directed scenarios.
module tb_e1_rx_bd_sched;
  localparam int MFW   = 3;
  localparam int RING  = 1 << MFW;
  localparam int PMASK = (1 << (MFW + 1)) - 1;

  logic           clk, rst;
  logic           ctrl_run, ctrl_flush, rel_stb, cnt_clr;
  logic [MFW-1:0] bri_data;
  logic           bri_wren, bri_full;
  logic [MFW+1:0] bro_data;
  logic           bro_rden, bro_empty;
  logic           cmp_valid;
  logic [MFW-1:0] cmp_mf;
  logic [1:0]     cmp_crc_e;
  logic           cmp_ack;
  logic [1:0]     st_state;
  logic [MFW:0]   st_inflight;
  logic           st_seq_err;
  logic [15:0]    crc_err_cnt;
  logic           irq;

  e1_rx_bd_sched #(.MFW(MFW)) dut (
    .clk(clk), .rst(rst),
    .ctrl_run(ctrl_run), .ctrl_flush(ctrl_flush), .rel_stb(rel_stb), .cnt_clr(cnt_clr),
    .bri_data(bri_data), .bri_wren(bri_wren), .bri_full(bri_full),
    .bro_data(bro_data), .bro_rden(bro_rden), .bro_empty(bro_empty),
    .cmp_valid(cmp_valid), .cmp_mf(cmp_mf), .cmp_crc_e(cmp_crc_e), .cmp_ack(cmp_ack),
    .st_state(st_state), .st_inflight(st_inflight), .st_seq_err(st_seq_err),
    .crc_err_cnt(crc_err_cnt), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pointers are free-running counts, compared modulo the pointer width.
  int             m_st, m_sub, m_done, m_rel, m_cnt, m_bri_data;
  bit             m_wren, m_rden, m_cv, m_seq;
  logic [MFW-1:0] m_mf;
  logic [1:0]     m_crc;
  bit             pre_arm;
  int             pre_val;

  always @(posedge clk or posedge rst) begin : model
    int occ, zeros;
    bit sub_ev, pop_ev, rel_ok, drained, mis;
    if (rst) begin
      m_st = 0; m_sub = 0; m_done = 0; m_rel = 0; m_cnt = 0; m_bri_data = 0;
      m_wren = 0; m_rden = 0; m_cv = 0; m_seq = 0; m_mf = '0; m_crc = '0;
    end else begin
      if (pre_arm) m_cnt = pre_val;
      occ     = (m_sub - m_rel) & PMASK;
      sub_ev  = (m_st == 1) && !bri_full && !m_wren && (occ < RING);
      pop_ev  = (m_st != 0) && !bro_empty && !m_rden && (!m_cv || cmp_ack);
      rel_ok  = (m_rel & PMASK) != (m_done & PMASK);
      drained = (m_done & PMASK) == (m_sub & PMASK);
`ifdef E1_RX_BD_SCHED_SEQCHK_EN
      mis = pop_ev && (int'(bro_data[MFW-1:0]) != (m_done % RING));
`else
      mis = 0;
`endif
      zeros = (bro_data[MFW+1] ? 0 : 1) + (bro_data[MFW] ? 0 : 1);
      if (pop_ev) begin
        m_cv  = 1;
        m_mf  = bro_data[MFW-1:0];
        m_crc = bro_data[MFW+1:MFW];
        m_cnt = (m_cnt + zeros > 65535) ? 65535 : m_cnt + zeros;
      end else if (cmp_ack) begin
        m_cv = 0;
      end
      if (cnt_clr) m_cnt = 0;
      if (m_st == 0 && ctrl_run) m_seq = 0;
      if (mis || (rel_stb && !rel_ok)) m_seq = 1;
      if (rel_stb && rel_ok) m_rel++;
      if (pop_ev) m_done++;
      m_wren = sub_ev;
      m_rden = pop_ev;
      if (sub_ev) begin
        m_bri_data = m_sub % RING;
        m_sub++;
      end
      case (m_st)
        0: if (ctrl_run) m_st = 1;
        1: if (!ctrl_run) m_st = 2;
        default: begin
          if (ctrl_flush) begin
            m_st  = 0;
            m_sub = m_done;
          end else if (ctrl_run) m_st = 1;
          else if (drained) m_st = 0;
        end
      endcase
    end
  end

  int total, bad;
  int bri_q[$];
  logic [MFW+1:0] bro_q[$];
  int dut_wr[$];
  logic [MFW+1:0] dut_cmp[$];
  int bri_depth;
  bit core_en;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("st_state",    int'(st_state),    m_st);
    check("bri_wren",    int'(bri_wren),    int'(m_wren));
    check("bri_data",    int'(bri_data),    m_bri_data);
    check("bro_rden",    int'(bro_rden),    int'(m_rden));
    check("cmp_valid",   int'(cmp_valid),   int'(m_cv));
    check("cmp_mf",      int'(cmp_mf),      int'(m_mf));
    check("cmp_crc_e",   int'(cmp_crc_e),   int'(m_crc));
    check("st_inflight", int'(st_inflight), (m_sub - m_done) & PMASK);
    check("st_seq_err",  int'(st_seq_err),  int'(m_seq));
    check("crc_err_cnt", int'(crc_err_cnt), m_cnt);
    check("irq",         int'(irq),         int'(m_cv | m_seq));
  endtask

  // One cycle: compare, log DUT transfers, then present FIFO flags for the coming edge
  // before applying the write/pop that edge performs.
  task automatic tick();
    int mf;
    @(negedge clk);
    compare_all();
    if (bri_wren) dut_wr.push_back(int'(bri_data));
    if (bro_rden) dut_cmp.push_back({cmp_crc_e, cmp_mf});
    rel_stb = 0; cnt_clr = 0; ctrl_flush = 0;
    bri_full  = (bri_q.size() >= bri_depth);
    bro_empty = (bro_q.size() == 0);
    bro_data  = bro_empty ? '0 : bro_q[0];
    if (m_wren) bri_q.push_back(m_bri_data);
    if (m_rden && bro_q.size() > 0) void'(bro_q.pop_front());
    if (core_en && bri_q.size() > 0 && $urandom_range(0, 2) == 0) begin
      mf = bri_q.pop_front();
      if ($urandom_range(0, 14) == 0) mf = mf ^ 1;
      bro_q.push_back({2'($urandom_range(0, 3)), MFW'(mf)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_all();
    rst = 1;
    ctrl_run = 0; ctrl_flush = 0; rel_stb = 0; cnt_clr = 0; cmp_ack = 0;
    #1;
    check("arst_state",  int'(st_state),    0);
    check("arst_valid",  int'(cmp_valid),   0);
    check("arst_wren",   int'(bri_wren),    0);
    check("arst_rden",   int'(bro_rden),    0);
    check("arst_inflt",  int'(st_inflight), 0);
    check("arst_seq",    int'(st_seq_err),  0);
    check("arst_cnt",    int'(crc_err_cnt), 0);
    check("arst_irq",    int'(irq),         0);
    @(negedge clk);
    compare_all();
    bri_q.delete();
    bro_q.delete();
    rst = 0;
    bri_full  = (0 >= bri_depth);
    bro_empty = 1;
    bro_data  = '0;
  endtask

  int bw, bc;

  initial begin
    total = 0; bad = 0;
    rst = 1; ctrl_run = 0; ctrl_flush = 0; rel_stb = 0; cnt_clr = 0; cmp_ack = 0;
    bri_full = 0; bro_empty = 1; bro_data = '0;
    pre_arm = 0; pre_val = 0; core_en = 0; bri_depth = 16;
    repeat (2) @(negedge clk);
    check("rst_state", int'(st_state),  0);
    check("rst_irq",   int'(irq),       0);

    // Ring fill: exactly 2^MFW submits, then stall.
    do_reset();
    bw = dut_wr.size(); bc = dut_cmp.size();
    ctrl_run = 1; cmp_ack = 1;
    repeat (30) tick();
    check("fill_count", dut_wr.size() - bw, 8);
    for (int i = 0; i < 8; i++) check("fill_mf", dut_wr[bw + i], i);
    check("fill_inflight", int'(st_inflight), 8);
    bro_q.push_back({2'b11, 3'd0});
    bro_q.push_back({2'b01, 3'd1});
    bro_q.push_back({2'b00, 3'd2});
    repeat (12) tick();
    check("cmp_count", dut_cmp.size() - bc, 3);
    for (int i = 0; i < 3; i++) check("cmp_order", int'(dut_cmp[bc + i][MFW-1:0]), i);
    check("crc_sum3", int'(crc_err_cnt), 3);
    check("model_cnt3", m_cnt, 3);
    check("seq_clean", int'(st_seq_err), 0);
    check("inflight5", int'(st_inflight), 5);
    rel_stb = 1; tick(); repeat (6) tick();
    check("resub_count", dut_wr.size() - bw, 9);
    check("resub_mf0", dut_wr[bw + 8], 0);
    rel_stb = 1; tick(); repeat (3) tick();
    rel_stb = 1; tick(); repeat (6) tick();
    check("resub_count3", dut_wr.size() - bw, 11);
    check("seq_before_bad_rel", int'(st_seq_err), 0);
    rel_stb = 1; tick(); repeat (6) tick();
    check("bad_rel_seq", int'(st_seq_err), 1);
    check("bad_rel_irq", int'(irq), 1);
    check("bad_rel_noresub", dut_wr.size() - bw, 11);
    check("bad_rel_inflight", int'(st_inflight), 8);

    // Out-of-order completion.
    bri_depth = 0;
    do_reset();
    ctrl_run = 1;
    tick();
    bro_q.push_back({2'b11, 3'd5});
    repeat (8) tick();
    check("ooo_mf", int'(cmp_mf), 5);
    check("ooo_valid", int'(cmp_valid), 1);
    check("ooo_irq", int'(irq), 1);
    check("ooo_inflight", int'(st_inflight), 15);
`ifdef E1_RX_BD_SCHED_SEQCHK_EN
    check("ooo_seq", int'(st_seq_err), 1);
`else
    check("ooo_seq", int'(st_seq_err), 0);
`endif

    // Drain to IDLE once all three in-flight BDs return.
    bri_depth = 3;
    do_reset();
    ctrl_run = 1;
    repeat (12) tick();
    check("drain_inflight3", int'(st_inflight), 3);
    ctrl_run = 0;
    tick(); tick();
    check("drain_state", int'(st_state), 2);
    cmp_ack = 1;
    bro_q.push_back({2'b11, 3'd0});
    bro_q.push_back({2'b11, 3'd1});
    bro_q.push_back({2'b11, 3'd2});
    repeat (12) tick();
    check("drain_idle", int'(st_state), 0);
    check("drain_inflight0", int'(st_inflight), 0);

    // Flush out of DRAIN.
    do_reset();
    ctrl_run = 1;
    repeat (12) tick();
    ctrl_run = 0;
    tick();
    check("flush_pre_state", int'(st_state), 2);
    ctrl_flush = 1;
    tick();
    check("flush_state", int'(st_state), 0);
    check("flush_inflight", int'(st_inflight), 0);

    // Counter saturation and clear priority.
    bri_depth = 0;
    do_reset();
    ctrl_run = 1; cmp_ack = 1;
    tick();
    force dut.crc_cnt = 16'hFFFE;
    pre_val = 16'hFFFE; pre_arm = 1;
    #1 release dut.crc_cnt;
    tick();
    pre_arm = 0;
    check("preload", int'(crc_err_cnt), 16'hFFFE);
    bro_q.push_back({2'b00, 3'd0});
    repeat (6) tick();
    check("saturate", int'(crc_err_cnt), 16'hFFFF);
    bro_q.push_back({2'b00, 3'd1});
    tick();
    cnt_clr = 1;
    tick();
    check("clr_pop_mf", int'(cmp_mf), 1);
    check("clr_wins", int'(crc_err_cnt), 0);

    // Randomized traffic through the emulated FIFOs and RX core.
    bri_depth = 3;
    do_reset();
    core_en = 1; ctrl_run = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 39) == 0) ctrl_run = ~ctrl_run;
      rel_stb    = ($urandom_range(0, 2) == 0);
      cmp_ack    = ($urandom_range(0, 1) == 0);
      ctrl_flush = ($urandom_range(0, 29) == 0);
      cnt_clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) bri_depth = int'($urandom_range(0, 4));
      if (i == 2000) begin
        do_reset();
        ctrl_run = 1;
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
